imem_boot_loader: RTL

- Controller that owns the instruction memory write port and sequences program loading from a byte stream (UART receiver) into the synchronous word-addressed instruction RAM.
- Holds the processor in reset while loading. Outside a load it passes the processor fetch address through to the RAM read address.
- Sits between the UART RX, the processor core fetch port and the instruction memory array.

---
 rtl/imem_boot_loader_if.sv | 20 ++
 rtl/imem_boot_loader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/imem_boot_loader_if.sv
// Boot loader bundle: UART RX byte stream, CPU fetch/reset control, instruction RAM write port.
interface imem_boot_loader_if #(parameter int ADDR_WIDTH = 12);
  logic                  start;
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [31:0]           cpu_addr;
  logic                  cpu_reset;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  mem_we;
  logic                  busy;
  logic                  done;
  logic                  error;

  modport master (output start, rx_data, rx_valid, cpu_addr,
                  input  rx_ready, cpu_reset, mem_addr, mem_wdata, mem_we, busy, done, error);
  modport slave  (input  start, rx_data, rx_valid, cpu_addr,
                  output rx_ready, cpu_reset, mem_addr, mem_wdata, mem_we, busy, done, error);
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed little-endian word stream from a byte source into instruction RAM,
// holding the CPU in reset meanwhile; outside a load the CPU fetch address drives the RAM.
module imem_boot_loader #(
  parameter int ADDR_WIDTH     = 12,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  imem_boot_loader_if.slave bus
);
  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0]     MAX_WORDS = 32'(1) << ADDR_WIDTH;
  localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]   TMO_ONE   = TW'(1);
  localparam logic [ADDR_WIDTH:0] PTR_ONE = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_DATA, ST_WRITE, ST_FINISH, ST_ERR} state_e;

  state_e              state_q, state_d;
  logic [1:0]          bcnt_q;
  logic [31:0]         word_q;
  logic [ADDR_WIDTH:0] wptr_q, len_q;
  logic [TW-1:0]       tmo_q;
  logic [31:0]         mem_wdata_q;
  logic                rx_ready_q, cpu_reset_q, mem_we_q, done_q, error_q;

  logic                accept, last_byte, tmo_hit, restart;
  logic [31:0]         word_nx;
  logic [ADDR_WIDTH:0] wptr_inc;

  assign accept    = bus.rx_valid && rx_ready_q;
  assign last_byte = (bcnt_q == 2'd3);
  assign tmo_hit   = (tmo_q == TMO_LAST);
  assign restart   = bus.start && ((state_q == ST_IDLE) || (state_q == ST_ERR));
  // Right shift so the first byte of each group lands in bits 7:0.
  assign word_nx   = {bus.rx_data, word_q[31:8]};
  assign wptr_inc  = wptr_q + PTR_ONE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.start) state_d = ST_HDR;
      ST_HDR: begin
        if (accept && last_byte) begin
          if (word_nx == 32'd0)          state_d = ST_FINISH;
          else if (word_nx > MAX_WORDS)  state_d = ST_ERR;
          else                           state_d = ST_DATA;
        end else if (!accept && tmo_hit) begin
          state_d = ST_ERR;
        end
      end
      ST_DATA: begin
        if (accept && last_byte)     state_d = ST_WRITE;
        else if (!accept && tmo_hit) state_d = ST_ERR;
      end
      ST_WRITE:  state_d = (wptr_inc == len_q) ? ST_FINISH : ST_DATA;
      ST_FINISH: state_d = ST_IDLE;
      ST_ERR:    if (bus.start) state_d = ST_HDR;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bcnt_q      <= '0;
      word_q      <= '0;
      wptr_q      <= '0;
      len_q       <= '0;
      tmo_q       <= '0;
      mem_wdata_q <= '0;
      rx_ready_q  <= 1'b0;
      cpu_reset_q <= 1'b0;
      mem_we_q    <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      // Outputs are decoded from the next state so they line up with the state register.
      rx_ready_q  <= (state_d == ST_HDR) || (state_d == ST_DATA);
      cpu_reset_q <= (state_d != ST_IDLE);
      mem_we_q    <= (state_d == ST_WRITE);
      done_q      <= (state_d == ST_FINISH);
      error_q     <= (state_d == ST_ERR);

      if (restart) begin
        bcnt_q <= '0;
        tmo_q  <= '0;
        wptr_q <= '0;
        len_q  <= '0;
      end else if (accept) begin
        bcnt_q <= bcnt_q + 2'd1;
        word_q <= word_nx;
        tmo_q  <= '0;
        if (last_byte && (state_q == ST_HDR)) begin
          len_q  <= word_nx[ADDR_WIDTH:0];
          wptr_q <= '0;
        end
        if (last_byte && (state_q == ST_DATA)) mem_wdata_q <= word_nx;
      end else if ((state_q == ST_HDR) || (state_q == ST_DATA)) begin
        tmo_q <= tmo_q + TMO_ONE;
      end else if (state_q == ST_WRITE) begin
        wptr_q <= wptr_inc;
      end
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.cpu_reset = cpu_reset_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.done      = done_q;
  assign bus.error     = error_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.mem_addr  = (state_q == ST_IDLE) ? bus.cpu_addr[ADDR_WIDTH+1:2]
                                              : wptr_q[ADDR_WIDTH-1:0];

  logic unused_cpu_bits;
  assign unused_cpu_bits = ^{bus.cpu_addr[31:ADDR_WIDTH+2], bus.cpu_addr[1:0]};
endmodule
